// File: rtl/pwm_peripheral_if.sv
// Register-side bundle of the PWM block: enable/mode/duty in, pins out.
// master = register block / bench, slave = pwm_peripheral.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out,
    input  period_start
  );

  modport slave (
    input  en_reg_out_7_0,
    input  en_reg_out_15_8,
    input  en_reg_pwm_7_0,
    input  en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out,
    output period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin output block driven low, high, or by one shared 8-bit PWM.
// Ports: clk, rst_n (async low), bus (slave): enables, duty in; out, period_start.
module pwm_peripheral #(
  parameter int CLK_DIV = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_peripheral_if.slave bus
);

  logic [11:0] pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [15:0] out_q, out_d;
  logic        ps_q;

  logic        tick;
  logic        ps;
  logic [7:0]  duty_eff;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  assign tick = (pre_q == 12'(CLK_DIV - 1));
  assign ps   = (pre_q == '0) && (cnt_q == '0);

  // A new period uses the duty present in its first cycle.
  assign duty_eff = ps ? bus.pwm_duty_cycle : shadow_q;

  // 0xFF is special-cased so full duty has no one-step dip.
  assign pwm_sig = (duty_eff == 8'hFF) || (cnt_q < duty_eff);

  always_comb begin
    pre_d    = tick ? '0 : pre_q + 12'd1;
    cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
    shadow_d = ps ? bus.pwm_duty_cycle : shadow_q;
    // Enable wins over mode; PWM pins share one pwm_sig.
    out_d    = en_out & (~en_pwm | {16{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      ps_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      ps_q     <= ps;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = ps_q;

endmodule
